// File: rtl/pin_input_conditioner.sv
// Per-channel synchronizer, debouncer and edge detector for raw header pins.
// Optional per-channel rise-event counters when PIN_EVENT_CNT_EN is defined.
module pin_input_conditioner #(
    parameter int   N_CH        = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CYCLES  = 16,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         pin_in,
    input  logic                    en,
    output logic [N_CH-1:0]         pin_out,
    output logic [N_CH-1:0]         rise,
    output logic [N_CH-1:0]         fall,
    output logic                    changed,
    input  logic [$clog2(N_CH)-1:0] cnt_sel,
    input  logic                    cnt_clr,
    output logic [15:0]             cnt_val
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [N_CH-1:0] sync_r [SYNC_STAGES];
    logic [N_CH-1:0] sync_q;
    logic [CW-1:0]   cnt [N_CH];
    logic [CW-1:0]   nxt_cnt [N_CH];
    logic [N_CH-1:0] nxt_out;
    logic [N_CH-1:0] nxt_rise;
    logic [N_CH-1:0] nxt_fall;

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_r[s] <= {N_CH{INIT_LEVEL}};
        end else begin
            sync_r[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++)
                sync_r[s] <= sync_r[s-1];
        end
    end

    // A mismatch must persist DEB_CYCLES enabled edges before it is accepted.
    always_comb begin
        nxt_out  = pin_out;
        nxt_rise = '0;
        nxt_fall = '0;
        for (int c = 0; c < N_CH; c++) begin
            nxt_cnt[c] = '0;
            if (en && (sync_q[c] != pin_out[c])) begin
                if (cnt[c] == LAST) begin
                    nxt_out[c]  = sync_q[c];
                    nxt_rise[c] = sync_q[c];
                    nxt_fall[c] = !sync_q[c];
                end else begin
                    nxt_cnt[c] = cnt[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pin_out <= {N_CH{INIT_LEVEL}};
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int c = 0; c < N_CH; c++)
                cnt[c] <= '0;
        end else begin
            pin_out <= nxt_out;
            rise    <= nxt_rise;
            fall    <= nxt_fall;
            changed <= |(nxt_rise | nxt_fall);
            for (int c = 0; c < N_CH; c++)
                cnt[c] <= nxt_cnt[c];
        end
    end

`ifdef PIN_EVENT_CNT_EN
    logic [15:0] evt [N_CH];

    // Clear takes priority over a coincident rise on the same channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_val <= '0;
            for (int c = 0; c < N_CH; c++)
                evt[c] <= '0;
        end else begin
            cnt_val <= evt[cnt_sel];
            for (int c = 0; c < N_CH; c++) begin
                if (cnt_clr && (cnt_sel == ($clog2(N_CH))'(c)))
                    evt[c] <= '0;
                else if (rise[c] && (evt[c] != 16'hFFFF))
                    evt[c] <= evt[c] + 16'd1;
            end
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_sel, cnt_clr};
    assign cnt_val    = '0;
`endif

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed and randomized checks of pin_input_conditioner against a
// run-length reference model of sync delay, debounce and strobes.
module tb_pin_input_conditioner;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam int DB = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   pin_in;
    logic           en;
    logic [N-1:0]   pin_out;
    logic [N-1:0]   rise;
    logic [N-1:0]   fall;
    logic           changed;
    logic [2:0]     cnt_sel;
    logic           cnt_clr;
    logic [15:0]    cnt_val;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [N-1:0] m_hist [SS];
    int           m_run [N];
    logic [N-1:0] m_out;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
    logic         m_chg;
    logic [15:0]  m_evt [N];
    logic [15:0]  m_cv;

    pin_input_conditioner #(
        .N_CH(N), .SYNC_STAGES(SS), .DEB_CYCLES(DB), .INIT_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .en(en),
        .pin_out(pin_out), .rise(rise), .fall(fall), .changed(changed),
        .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_val(cnt_val)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Level seen by the debouncer = pin_in delayed SS edges; a new level is
    // accepted after DB consecutive enabled edges of disagreement.
    task automatic model_step();
        logic [N-1:0] seen;
        logic [N-1:0] nr;
        logic [N-1:0] nf;
        if (!rst_n) begin
            for (int s = 0; s < SS; s++) m_hist[s] = '0;
            for (int c = 0; c < N; c++) begin
                m_run[c] = 0;
                m_evt[c] = '0;
            end
            m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0; m_cv = '0;
            return;
        end
        seen = m_hist[SS-1];
`ifdef PIN_EVENT_CNT_EN
        m_cv = m_evt[cnt_sel];
        for (int c = 0; c < N; c++) begin
            if (cnt_clr && cnt_sel == 3'(c)) m_evt[c] = 0;
            else if (m_rise[c] && m_evt[c] < 16'hFFFF) m_evt[c] = m_evt[c] + 1;
        end
`else
        m_cv = '0;
`endif
        nr = '0;
        nf = '0;
        for (int c = 0; c < N; c++) begin
            if (en && seen[c] != m_out[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == DB) begin
                    m_out[c] = seen[c];
                    m_run[c] = 0;
                    if (seen[c]) nr[c] = 1'b1;
                    else nf[c] = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_rise = nr;
        m_fall = nf;
        m_chg  = |(nr | nf);
        for (int s = SS - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
        m_hist[0] = pin_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pin_out", 16'(pin_out), 16'(m_out));
        chk("rise", 16'(rise), 16'(m_rise));
        chk("fall", 16'(fall), 16'(m_fall));
        chk("changed", 16'(changed), 16'(m_chg));
        chk("cnt_val", cnt_val, m_cv);
    endtask

    int lat, rt, ft, nfall, nchg;

    initial begin
        rst_n = 0; pin_in = '0; en = 1; cnt_sel = 0; cnt_clr = 0;
        tick(); tick();
        chk("reset_pin_out", 16'(pin_out), 16'h0);
        chk("reset_cnt_val", cnt_val, 16'h0);
        rst_n = 1;
        tick();

        // 1: single clean rise on ch0
        pin_in[0] = 1;
        lat = 0;
        while (lat < 40 && !pin_out[0]) begin
            tick(); lat++;
        end
        chk("t1_latency", 16'(lat), 16'd18);
        chk("t1_rise0", 16'(rise), 16'h0001);
        chk("t1_changed", 16'(changed), 16'h1);
        tick();
        chk("t1_rise_one_cycle", 16'(rise), 16'h0);

        // 2: glitch on ch3 rejected, then a 17-cycle pulse passes
        pin_in[3] = 1;
        repeat (10) tick();
        pin_in[3] = 0;
        repeat (30) tick();
        chk("t2_glitch_out", 16'(pin_out[3]), 16'h0);
        pin_in[3] = 1;
        rt = 0; ft = 0; nfall = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 18) pin_in[3] = 0;
            tick();
            if (rise[3] && rt == 0) rt = i;
            if (fall[3]) begin
                nfall++;
                if (ft == 0) ft = i;
            end
        end
        chk("t2_rise_lat", 16'(rt), 16'd18);
        chk("t2_pulse_width", 16'(ft - rt), 16'd17);
        chk("t2_fall_count", 16'(nfall), 16'd1);

        // 3: simultaneous accepts on ch1 and ch5
        pin_in[1] = 1; pin_in[5] = 1;
        nchg = 0; rt = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (changed) nchg++;
            if (rise == 8'h22) rt = i;
        end
        chk("t3_changed_once", 16'(nchg), 16'd1);
        chk("t3_joint_rise", 16'(rt), 16'd18);

        // 4: en=0 freezes ch6, re-enable settles in DB cycles
        en = 0;
        pin_in[6] = 1;
        repeat (30) tick();
        chk("t4_frozen", 16'(pin_out[6]), 16'h0);
        en = 1;
        lat = 0;
        while (lat < 40 && !pin_out[6]) begin
            tick(); lat++;
        end
        chk("t4_reenable_lat", 16'(lat), 16'd16);

        // 5: reset mid-debounce on ch7
        pin_in[7] = 1;
        repeat (SS + 12) tick();
        rst_n = 0;
        tick();
        chk("t5_reset_out", 16'(pin_out), 16'h0);
        chk("t5_reset_strobe", 16'(rise | fall), 16'h0);
        rst_n = 1;
        lat = 0;
        while (lat < 40 && !pin_out[7]) begin
            tick(); lat++;
        end
        chk("t5_relatency", 16'(lat), 16'd18);

`ifdef PIN_EVENT_CNT_EN
        // 6: event counter on ch2
        cnt_clr = 1; cnt_sel = 2; tick(); cnt_clr = 0;
        for (int k = 0; k < 3; k++) begin
            pin_in[2] = 1; repeat (20) tick();
            pin_in[2] = 0; repeat (20) tick();
        end
        cnt_sel = 2;
        tick();
        chk("t6_count3", cnt_val, 16'd3);
        pin_in[2] = 1;
        lat = 0;
        while (lat < 40 && !rise[2]) begin
            tick(); lat++;
        end
        cnt_clr = 1; tick(); cnt_clr = 0; tick();
        chk("t6_clr_wins", cnt_val, 16'd0);
        pin_in[2] = 0; repeat (20) tick();
`endif

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) pin_in[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 149) == 0) en = ~en;
            if (!en && $urandom_range(0, 19) == 0) en = 1;
            rst_n = ($urandom_range(0, 799) != 0);
            cnt_sel = 3'($urandom_range(0, N-1));
            cnt_clr = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
